alu_stream_pipe: RTL and testbench
==================================

// Module: alu_stream_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined successor of the ALU datapath. Operand and opcode beats enter over a
//  valid/ready stream; results leave over a valid/ready stream, with error/overflow flags and a result counter.
//  Sits between the stimulus/sequencer side and the result scoreboard/consumer; sustains 1 op/cycle.
// PARAMETERS
//  IN_WIDTH   5  signed operand width (A, B)
//  OUT_WIDTH  6  result width; legal range OUT_WIDTH >= IN_WIDTH (elaboration error otherwise)
//  CNT_WIDTH  8  width of emitted-result counter
// PORTS
//  clk        in   1          clock, all state on posedge
//  rst_n      in   1          async active-low reset
//  in_valid   in   1          input beat valid
//  in_ready   out  1          input beat accepted when in_valid & in_ready
//  A          in   IN_WIDTH   signed operand A
//  B          in   IN_WIDTH   signed operand B
//  a_en       in   1          op-group select bit A
//  b_en       in   1          op-group select bit B
//  a_op       in   3          group-A opcode
//  b_op       in   2          group-B opcode
//  ALU_en     in   1          0: beat consumed, no result produced
//  out_valid  out  1          result valid
//  out_ready  in   1          result taken when out_valid & out_ready
//  C          out  OUT_WIDTH  result
//  out_err    out  1          illegal op for this result (C forced to 0)
//  out_ovf    out  1          signed overflow/saturation occurred (see CONFIGURATION)
//  op_count   out  CNT_WIDTH  number of results handed off (wraps)
// BEHAVIOUR
//  - Reset (async assert, sync-released by upstream): s1/s2 valid=0, out_valid=0, C=0, out_err=0,
//    out_ovf=0, op_count=0. In-flight beats are dropped; in_ready=1 from the first clock after release.
//  - Pipeline: S1 registers operands + decoded op; S2 registers computed result. Latency 2 cycles accept->out_valid.
//  - Handshake: stage advances when its successor is empty or draining; in_ready = ~s1_v | ~s2_v | out_ready.
//    out_valid stays high and C/flags stable until out_ready. No loss, duplication or reorder under any stall pattern.
//  - ALU_en=0 beat: accepted, not propagated (does not occupy S2, not counted).
//  - Arithmetic: A, B sign-extended to OUT_WIDTH+1; result truncated to OUT_WIDTH (wrap). Logic ops: bitwise on
//    IN_WIDTH, result sign-extended. out_ovf=1 iff the (OUT_WIDTH+1) arithmetic result does not fit OUT_WIDTH signed.
//  - {a_en,b_en}=10, a_op: 0 A+B, 1 A-B, 2 A^B, 3 A&B, 4 A|B, 5 ~(A^B), 6 A<<<1, 7 illegal.
//  - {a_en,b_en}=01, b_op: 0 ~(A&B), 1 A+B, 2 ~(A|B), 3 -B.
//  - {a_en,b_en}=11, b_op: 0 A+1, 1 B+1, 2 A-1, 3 B-1.
//  - {a_en,b_en}=00, or a_op=7: out_err=1, C=0, out_ovf=0; result still emitted and counted.
//  - op_count increments on each out_valid&out_ready; wraps 2^CNT_WIDTH-1 -> 0.
//  - Simultaneous accept + output handoff with pipeline full: both occur, occupancy unchanged.
// CONFIGURATION
//  - ALU_SAT_EN defined: on overflow, arithmetic ops clamp C to signed max (2^(OUT_WIDTH-1)-1) / min
//    (-2^(OUT_WIDTH-1)); out_ovf=1.
//  - ALU_SAT_EN undefined: results wrap; out_ovf still reports overflow. Port list identical in both builds.
// STRUCTURE
//  - alu_pkg: mode enum {MODE_ILLEGAL, MODE_A, MODE_B, MODE_INC}, a_op/b_op enums, decoded-op struct,
//    decode function (a_en,b_en,a_op,b_op -> op, err).
//  - Sub-module alu_exec: combinational compute (operands, decoded op -> result, ovf); saturation lives here.
//  - Top holds the two pipeline stages, handshake logic and op_count.
// TESTING (defaults unless stated)
//  - Reset mid-stream with 2 beats in flight -> out_valid=0, C=0, op_count=0; no stale result after release.
//  - A=7, B=-3, {a_en,b_en}=10, a_op=1, ALU_en=1 -> 2 cycles later C=6'b001010 (10), err=0, ovf=0.
//  - A=-16, B=-16, a_op=0 -> C=6'b100000 (-32), ovf=0; A=5, B=3, a_op=2 -> C=6'b000110.
//  - out_ready=0, push 4 beats -> in_ready falls after 2 accepts; release -> 4 results in order, op_count=4.
//  - {a_en,b_en}=00 and a_op=7 -> C=0, out_err=1, counted; ALU_en=0 beat -> no output, count unchanged.
//  - OUT_WIDTH=5, A=15, B=1, ADD -> with ALU_SAT_EN C=15, ovf=1; without C=-16, ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and opcode decode for the streaming ALU pipeline.
// Decode maps the raw group-select and opcode fields onto a mode, an opcode selector and an error flag.
package alu_pkg;

    typedef enum logic [1:0] {MODE_ILLEGAL, MODE_A, MODE_B, MODE_INC} mode_e;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_XOR, A_AND, A_OR, A_XNOR, A_SHL, A_ILL} a_op_e;
    typedef enum logic [1:0] {B_NAND, B_ADD, B_NOR, B_NEG} b_op_e;
    typedef enum logic [1:0] {INC_A, INC_B, DEC_A, DEC_B} inc_op_e;

    // sel carries a_op in MODE_A, otherwise {1'b0, b_op}
    typedef struct packed {
        mode_e      mode;
        logic [2:0] sel;
    } op_t;

    typedef struct packed {
        op_t  op;
        logic err;
    } dec_t;

    function automatic dec_t alu_decode(input logic a_en, input logic b_en,
                                        input logic [2:0] a_op, input logic [1:0] b_op);
        dec_t d;
        d.op.mode = MODE_ILLEGAL;
        d.op.sel  = a_op;
        d.err     = 1'b1;
        case ({a_en, b_en})
            2'b10: begin
                if (a_op_e'(a_op) != A_ILL) begin
                    d.op.mode = MODE_A;
                    d.err     = 1'b0;
                end
            end
            2'b01: begin
                d.op.mode = MODE_B;
                d.op.sel  = {1'b0, b_op};
                d.err     = 1'b0;
            end
            2'b11: begin
                d.op.mode = MODE_INC;
                d.op.sel  = {1'b0, b_op};
                d.err     = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU core: computes one result in OUT_WIDTH+1 bits, flags signed overflow.
// With ALU_SAT_EN defined, overflowing arithmetic clamps to the signed limits; otherwise it wraps.
module alu_exec
    import alu_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 6
) (
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    input  op_t                         op,
    output logic signed [OUT_WIDTH-1:0] c,
    output logic                        ovf
);

    localparam int EW = OUT_WIDTH + 1;

    logic signed [EW-1:0] ax, bx, r;
    logic                 arith;

    // Bitwise ops on sign-extended operands equal the sign-extended IN_WIDTH result
    assign ax = EW'(a);
    assign bx = EW'(b);

    always_comb begin
        r     = '0;
        arith = 1'b0;
        case (op.mode)
            MODE_A: begin
                case (a_op_e'(op.sel))
                    A_ADD:   begin r = ax + bx;  arith = 1'b1; end
                    A_SUB:   begin r = ax - bx;  arith = 1'b1; end
                    A_XOR:   r = ax ^ bx;
                    A_AND:   r = ax & bx;
                    A_OR:    r = ax | bx;
                    A_XNOR:  r = ~(ax ^ bx);
                    A_SHL:   begin r = ax <<< 1; arith = 1'b1; end
                    default: r = '0;
                endcase
            end
            MODE_B: begin
                case (b_op_e'(op.sel[1:0]))
                    B_NAND:  r = ~(ax & bx);
                    B_ADD:   begin r = ax + bx; arith = 1'b1; end
                    B_NOR:   r = ~(ax | bx);
                    default: begin r = -bx;     arith = 1'b1; end
                endcase
            end
            MODE_INC: begin
                arith = 1'b1;
                case (inc_op_e'(op.sel[1:0]))
                    INC_A:   r = ax + EW'(1);
                    INC_B:   r = bx + EW'(1);
                    DEC_A:   r = ax - EW'(1);
                    default: r = bx - EW'(1);
                endcase
            end
            default: r = '0;
        endcase
    end

    assign ovf = arith & (r[EW-1] ^ r[EW-2]);

`ifdef ALU_SAT_EN
    localparam logic signed [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
        return v[EW-1] ? SMIN : SMAX;
    endfunction

    assign c = ovf ? sat(r) : r[OUT_WIDTH-1:0];
`else
    assign c = r[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/alu_stream_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands and decoded op, S2 holds the result.
// Optional ALU_SAT_EN macro selects saturating arithmetic inside alu_exec.
module alu_stream_pipe
    import alu_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  A,
    input  logic signed [IN_WIDTH-1:0]  B,
    input  logic                        a_en,
    input  logic                        b_en,
    input  logic [2:0]                  a_op,
    input  logic [1:0]                  b_op,
    input  logic                        ALU_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] C,
    output logic                        out_err,
    output logic                        out_ovf,
    output logic [CNT_WIDTH-1:0]        op_count
);

    if (OUT_WIDTH < IN_WIDTH) begin : g_width_check
        $error("alu_stream_pipe: OUT_WIDTH must be >= IN_WIDTH");
    end

    logic                        vld_p1, vld_p2;
    logic signed [IN_WIDTH-1:0]  a_p1, b_p1;
    dec_t                        dec_p1;
    dec_t                        dec_in;
    logic signed [OUT_WIDTH-1:0] c_p2, c_ex;
    logic                        err_p2, ovf_p2, ovf_ex;
    logic                        s2_ready;

    assign dec_in   = alu_decode(a_en, b_en, a_op, b_op);
    assign s2_ready = ~vld_p2 | out_ready;
    assign in_ready = ~vld_p1 | s2_ready;

    // ---- stage 1: operand/op capture (ALU_en=0 beats are consumed here) ----
    always_ff @(posedge clk) begin
        if (in_valid && in_ready && ALU_en) begin
            a_p1   <= A;
            b_p1   <= B;
            dec_p1 <= dec_in;
        end
    end

    alu_exec #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_exec (
        .a   (a_p1),
        .b   (b_p1),
        .op  (dec_p1.op),
        .c   (c_ex),
        .ovf (ovf_ex)
    );

    // ---- stage 2: result register, output handshake and counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            c_p2     <= '0;
            err_p2   <= 1'b0;
            ovf_p2   <= 1'b0;
            op_count <= '0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid & ALU_en;
            end
            if (s2_ready) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    c_p2   <= c_ex;
                    err_p2 <= dec_p1.err;
                    ovf_p2 <= ovf_ex;
                end
            end
            if (vld_p2 && out_ready) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = vld_p2;
    assign C         = c_p2;
    assign out_err   = err_p2;
    assign out_ovf   = ovf_p2;

endmodule

// File: tb/tb_alu_stream_pipe.sv
// Self-checking bench for alu_stream_pipe: vector table + scoreboard, stall/reset sequences,
// and a narrow OUT_WIDTH=5 instance for the overflow/saturation boundary.
module tb_alu_stream_pipe;

    localparam int IW = 5;
    localparam int OW = 6;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 in_valid, in_ready;
    logic signed [IW-1:0] A, B;
    logic                 a_en, b_en, ALU_en;
    logic [2:0]           a_op;
    logic [1:0]           b_op;
    logic                 out_valid, out_ready;
    logic signed [OW-1:0] C;
    logic                 out_err, out_ovf;
    logic [CW-1:0]        op_count;

    alu_stream_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op), .ALU_en(ALU_en),
        .out_valid(out_valid), .out_ready(out_ready), .C(C), .out_err(out_err),
        .out_ovf(out_ovf), .op_count(op_count)
    );

    // Narrow instance: OUT_WIDTH == IN_WIDTH
    logic                 in_valid5, in_ready5, out_valid5, out_ready5, out_err5, out_ovf5;
    logic signed [IW-1:0] A5, B5, C5;
    logic [2:0]           a_op5;
    logic [CW-1:0]        op_count5;

    alu_stream_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(5), .CNT_WIDTH(CW)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .A(A5), .B(B5), .a_en(1'b1), .b_en(1'b0), .a_op(a_op5), .b_op(2'b00), .ALU_en(1'b1),
        .out_valid(out_valid5), .out_ready(out_ready5), .C(C5), .out_err(out_err5),
        .out_ovf(out_ovf5), .op_count(op_count5)
    );

    typedef struct {
        logic signed [OW-1:0] c;
        logic                 err;
        logic                 ovf;
    } res_t;

    typedef struct {
        int a, b;
        bit ae, be;
        int aop, bop;
        int c;
        bit err;
    } vec_t;

    res_t sb[$];
    int   checks     = 0;
    int   passes     = 0;
    int   stall_mode = 0;   // 0 always ready, 1 never ready, 2 random
    int   exp_count  = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Independent integer reference model for the 6-bit build
    function automatic res_t model(input int a, input int b, input bit ae, input bit be,
                                   input int aop, input int bop);
        res_t res;
        int   r = 0;
        bit   ar = 1'b1;
        bit   err = 1'b0;
        case ({ae, be})
            2'b10: case (aop)
                0: r = a + b;
                1: r = a - b;
                2: begin r = a ^ b;    ar = 0; end
                3: begin r = a & b;    ar = 0; end
                4: begin r = a | b;    ar = 0; end
                5: begin r = ~(a ^ b); ar = 0; end
                6: r = a * 2;
                default: begin err = 1; ar = 0; end
            endcase
            2'b01: case (bop)
                0: begin r = ~(a & b); ar = 0; end
                1: r = a + b;
                2: begin r = ~(a | b); ar = 0; end
                default: r = -b;
            endcase
            2'b11: case (bop)
                0: r = a + 1;
                1: r = b + 1;
                2: r = a - 1;
                default: r = b - 1;
            endcase
            default: begin err = 1; ar = 0; end
        endcase
        res.err = err;
        res.ovf = ar && (r > (1 << (OW-1)) - 1 || r < -(1 << (OW-1)));
        res.c   = err ? '0 : OW'(r);
`ifdef ALU_SAT_EN
        if (res.ovf) res.c = (r < 0) ? OW'(-(1 << (OW-1))) : OW'((1 << (OW-1)) - 1);
`endif
        return res;
    endfunction

    task automatic send(input int a, input int b, input bit ae, input bit be,
                        input int aop, input int bop, input bit en, input res_t exp);
        int n = 0;
        @(negedge clk);
        A = IW'(a); B = IW'(b); a_en = ae; b_en = be;
        a_op = 3'(aop); b_op = 2'(bop); ALU_en = en; in_valid = 1'b1;
        #2;
        while (!in_ready && n < 100) begin
            @(negedge clk); #2; n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            if (en) sb.push_back(exp);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Output side: stall pattern plus scoreboard compare at each handshake
    initial begin
        res_t r;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (stall_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    r = sb.pop_front();
                    chk("C", int'(C), int'(r.c));
                    chk("out_err", int'(out_err), int'(r.err));
                    chk("out_ovf", int'(out_ovf), int'(r.ovf));
                    chk("op_count", int'(op_count), exp_count & 255);
                    exp_count++;
                end
            end
        end
    end

    task automatic test5(input int a, input int b, input int aop, input int c_req, input bit ovf_req);
        int n = 0;
        @(negedge clk);
        A5 = IW'(a); B5 = IW'(b); a_op5 = 3'(aop); in_valid5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        while (!out_valid5 && n < 10) begin
            @(negedge clk); n++;
        end
        chk("w5_C", int'(C5), c_req);
        chk("w5_ovf", int'(out_ovf5), int'(ovf_req));
    endtask

    vec_t vt[$];

    initial begin
        int   cnt0;
        res_t e;
        vt = '{
            '{7,   -3,  1, 0, 1, 0,  10, 0},
            '{-16, -16, 1, 0, 0, 0, -32, 0},
            '{5,   3,   1, 0, 2, 0,   6, 0},
            '{5,   3,   1, 0, 3, 0,   1, 0},
            '{5,   3,   1, 0, 4, 0,   7, 0},
            '{5,   3,   1, 0, 5, 0,  -7, 0},
            '{-16, 0,   1, 0, 6, 0, -32, 0},
            '{15,  0,   1, 0, 6, 0,  30, 0},
            '{15,  -16, 1, 0, 1, 0,  31, 0},
            '{5,   3,   0, 1, 0, 0,  -2, 0},
            '{-5,  -7,  0, 1, 0, 1, -12, 0},
            '{5,   3,   0, 1, 0, 2,  -8, 0},
            '{0,   -16, 0, 1, 0, 3,  16, 0},
            '{15,  0,   1, 1, 0, 0,  16, 0},
            '{0,   -1,  1, 1, 0, 1,   0, 0},
            '{-16, 0,   1, 1, 0, 2, -17, 0},
            '{0,   0,   1, 1, 0, 3,  -1, 0},
            '{9,   4,   0, 0, 0, 0,   0, 1},
            '{9,   4,   1, 0, 7, 0,   0, 1}
        };

        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; a_en = 0; b_en = 0;
        a_op = '0; b_op = '0; ALU_en = 1'b1;
        in_valid5 = 1'b0; out_ready5 = 1'b1; A5 = '0; B5 = '0; a_op5 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_C", int'(C), 0);
        chk("rst_flags", int'({out_err, out_ovf}), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Vector table, back-to-back with no stalls
        stall_mode = 0;
        foreach (vt[i]) begin
            e.c = OW'(vt[i].c); e.err = vt[i].err; e.ovf = 1'b0;
            send(vt[i].a, vt[i].b, vt[i].ae, vt[i].be, vt[i].aop, vt[i].bop, 1'b1, e);
        end
        drain();
        chk("count_after_table", int'(op_count), vt.size());

        // Backpressure: two beats fill the pipe, then in_ready drops
        stall_mode = 1;
        cnt0 = int'(op_count);
        for (int i = 0; i < 2; i++)
            send(i + 1, 2, 1, 0, 0, 0, 1, model(i + 1, 2, 1, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);
        in_valid = 1'b0;
        stall_mode = 0;
        for (int i = 2; i < 4; i++)
            send(i + 1, 2, 1, 0, 0, 0, 1, model(i + 1, 2, 1, 0, 0, 0));
        drain();
        chk("count_after_bp", int'(op_count), (cnt0 + 4) & 255);

        // ALU_en=0 beat is swallowed
        cnt0 = int'(op_count);
        send(3, 3, 1, 0, 0, 0, 0, model(3, 3, 1, 0, 0, 0));
        repeat (5) @(negedge clk);
        chk("en0_count", int'(op_count), cnt0);
        chk("en0_out_valid", int'(out_valid), 0);

        // Reset with two beats in flight
        stall_mode = 1;
        send(1, 1, 1, 0, 0, 0, 1, model(1, 1, 1, 0, 0, 0));
        send(2, 2, 1, 0, 0, 0, 1, model(2, 2, 1, 0, 0, 0));
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_C", int'(C), 0);
        chk("midrst_op_count", int'(op_count), 0);
        sb.delete();
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        stall_mode = 0;
        repeat (4) @(negedge clk);
        #2;
        chk("post_rst_no_stale", int'(out_valid), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Random stream under random stalls
        stall_mode = 2;
        for (int i = 0; i < 300; i++) begin
            int  a, b, aop, bop;
            bit  ae, be, en;
            a   = int'($signed(IW'($urandom_range(0, 31))));
            b   = int'($signed(IW'($urandom_range(0, 31))));
            ae  = 1'($urandom_range(0, 1));
            be  = 1'($urandom_range(0, 1));
            aop = int'($urandom_range(0, 7));
            bop = int'($urandom_range(0, 3));
            en  = ($urandom_range(0, 7) != 0);
            send(a, b, ae, be, aop, bop, en, model(a, b, ae, be, aop, bop));
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        stall_mode = 0;
        drain();
        chk("count_after_random", int'(op_count), exp_count & 255);

        // Narrow output: overflow boundary
`ifdef ALU_SAT_EN
        test5(15, 1, 0, 15, 1'b1);
        test5(-16, -1, 0, -16, 1'b1);
`else
        test5(15, 1, 0, -16, 1'b1);
        test5(-16, -1, 0, 15, 1'b1);
`endif
        test5(7, 7, 0, 14, 1'b0);
        test5(-16, 0, 3, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
